// File: rtl/time_set_ctrl_if.sv
// Front-panel button inputs and time-set outputs exchanged with the clock datapath.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       open;
    logic       sec_add;
    logic       min_add;
    logic       hour_add;
    logic [2:0] field_sel;
    logic       blink;

    modport master (
        output btn_mode, btn_inc,
        input  open, sec_add, min_add, hour_add, field_sel, blink
    );

    modport slave (
        input  btn_mode, btn_inc,
        output open, sec_add, min_add, hour_add, field_sel, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button conditioning plus set-mode FSM driving the clock's field increment pulses.
// Press event lands DEBOUNCE_CYC+2 cycles after a clean raw rise; no backpressure, outputs are registered.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYC     = 500000,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000,
    parameter int PULSE_CYC        = 4,
    parameter int BLINK_CYC        = 12500000
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RP_W   = $clog2(RP_MAX) + 1;
    localparam int PL_W   = $clog2(PULSE_CYC) + 1;
    localparam int BL_W   = $clog2(BLINK_CYC) + 1;

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    // Index 0 = mode button, index 1 = inc button.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_d;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {bus.btn_inc, bus.btn_mode};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic mode_ev;
    logic inc_ev;
    logic inc_level;

    assign mode_ev   = press[0];
    assign inc_ev    = press[1];
    assign inc_level = stable[1];

    function automatic state_t next_of(input state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return RUN;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input state_t s);
        case (s)
            SET_HOUR: return 3'b100;
            SET_MIN:  return 3'b010;
            SET_SEC:  return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

    state_t          state;
    logic            open_r;
    logic [2:0]      field_r;
    logic            blink_r;
    logic [BL_W-1:0] blink_cnt;
    logic [2:0]      adds;
    logic [PL_W-1:0] pulse_cnt;
    logic            rep_on;
    logic            rep_first;
    logic [RP_W-1:0] rep_cnt;
    logic            inc_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            open_r    <= 1'b1;
            field_r   <= 3'b000;
            blink_r   <= 1'b0;
            blink_cnt <= '0;
            adds      <= 3'b000;
            pulse_cnt <= '0;
            rep_on    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
            inc_block <= 1'b0;
        end else begin
            // adds holds the target latched at pulse start, so a mode change never redirects it
            if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end else begin
                adds <= 3'b000;
            end

            if (!inc_level) begin
                inc_block <= 1'b0;
            end

            if (state == RUN) begin
                blink_cnt <= '0;
                blink_r   <= 1'b0;
            end else if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                blink_r   <= ~blink_r;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (mode_ev) begin
                state     <= next_of(state);
                open_r    <= (next_of(state) == RUN);
                field_r   <= sel_of(next_of(state));
                blink_cnt <= '0;
                blink_r   <= 1'b0;
                rep_on    <= 1'b0;
                // a coincident inc press is swallowed until the button is released
                if (inc_ev) begin
                    inc_block <= 1'b1;
                end
            end else if (inc_ev && state != RUN && !inc_block) begin
                adds      <= field_r;
                pulse_cnt <= PL_W'(PULSE_CYC - 1);
                rep_on    <= 1'b1;
                rep_first <= 1'b1;
                rep_cnt   <= RP_W'(1);
            end else if (rep_on) begin
                if (!inc_level) begin
                    rep_on <= 1'b0;
                end else if (rep_cnt == (rep_first ? RP_W'(REPEAT_DELAY_CYC) : RP_W'(REPEAT_RATE_CYC))) begin
                    adds      <= field_r;
                    pulse_cnt <= PL_W'(PULSE_CYC - 1);
                    rep_first <= 1'b0;
                    rep_cnt   <= RP_W'(1);
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.open      = open_r;
    assign bus.field_sel = field_r;
    assign bus.blink     = blink_r;
    assign bus.hour_add  = adds[2];
    assign bus.min_add   = adds[1];
    assign bus.sec_add   = adds[0];
endmodule

// File: tb/tb_time_set_ctrl.sv
// Table-driven and randomized checks of time_set_ctrl against an event-level reference model.
module tb_time_set_ctrl;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int P  = 2;
    localparam int B  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
        .PULSE_CYC(P), .BLINK_CYC(B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] dut_out;
    assign dut_out = {bus.open, bus.field_sel, bus.hour_add, bus.min_add, bus.sec_add, bus.blink};

    // Reference model: per-edge histories, everything else derived arithmetically from them.
    bit rst_q[$];
    bit rawm_q[$];
    bit rawi_q[$];
    bit stm_q[$];
    bit sti_q[$];
    bit evm_q[$];
    bit evi_q[$];
    int m_state = 0;
    int m_entry = 0;
    int p_first = 0;
    int p_last  = -1;
    int press_e = 0;
    logic [2:0] p_line = 3'b000;
    bit rep_on = 0;
    bit blk    = 0;
    logic [7:0] exp_out;

    function automatic logic [2:0] field_of(input int s);
        case (s)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Synchronised level as seen by the debouncer at edge j.
    function automatic bit sv_of(input int j, input bit isinc);
        if (j < 2) return 1'b0;
        if (rst_q[j-1] || rst_q[j-2]) return 1'b0;
        return isinc ? rawi_q[j-2] : rawm_q[j-2];
    endfunction

    // Stable level flips when the last D synced samples (all after reset) disagree with it.
    function automatic bit next_stable(input int n, input bit isinc);
        bit prev;
        prev = (n > 0) ? (isinc ? sti_q[n-1] : stm_q[n-1]) : 1'b0;
        for (int k = 0; k < D; k++) begin
            int j;
            j = n - k;
            if (j < 0) return prev;
            if (j < n && rst_q[j]) return prev;
            if (sv_of(j, isinc) == prev) return prev;
        end
        return !prev;
    endfunction

    task automatic start_pulse(input int n, input int st);
        p_line  = field_of(st);
        p_first = n;
        p_last  = n + P - 1;
    endtask

    task automatic model_step(input bit rst, input bit rm, input bit ri);
        int n;
        int old;
        bit nsm, nsi, nem, nei, mev, iev, istab;
        logic [2:0] adds;
        bit bl;
        n = rst_q.size();
        if (rst) begin
            rst_q.push_back(1'b1);
            rawm_q.push_back(1'b0); rawi_q.push_back(1'b0);
            stm_q.push_back(1'b0);  sti_q.push_back(1'b0);
            evm_q.push_back(1'b0);  evi_q.push_back(1'b0);
            m_state = 0; m_entry = n; p_first = 0; p_last = -1;
            rep_on = 0; blk = 0;
        end else begin
            nsm   = next_stable(n, 1'b0);
            nsi   = next_stable(n, 1'b1);
            nem   = (n >= 2) && stm_q[n-1] && !stm_q[n-2];
            nei   = (n >= 2) && sti_q[n-1] && !sti_q[n-2];
            mev   = (n >= 1) && evm_q[n-1];
            iev   = (n >= 1) && evi_q[n-1];
            istab = (n >= 1) && sti_q[n-1];
            old   = m_state;
            if (!istab) blk = 0;
            if (mev) begin
                m_state = (m_state + 1) % 4;
                m_entry = n;
                rep_on  = 0;
                if (iev) blk = 1;
            end else if (iev && old != 0 && !blk) begin
                start_pulse(n, old);
                press_e = n - 1;
                rep_on  = 1;
            end else if (rep_on) begin
                if (!istab) rep_on = 0;
                else if ((n - 1 - press_e) >= RD && ((n - 1 - press_e - RD) % RR) == 0)
                    start_pulse(n, old);
            end
            rst_q.push_back(1'b0);
            rawm_q.push_back(rm); rawi_q.push_back(ri);
            stm_q.push_back(nsm); sti_q.push_back(nsi);
            evm_q.push_back(nem); evi_q.push_back(nei);
        end
        adds    = (n >= p_first && n <= p_last) ? p_line : 3'b000;
        bl      = (m_state == 0) ? 1'b0 : 1'(((n - m_entry) / B) % 2);
        exp_out = {(m_state == 0), field_of(m_state), adds, bl};
    endtask

    task automatic tick(input bit rst);
        bit rm, ri;
        rm = bus.btn_mode;
        ri = bus.btn_inc;
        reset = rst;
        @(posedge clk);
        model_step(rst, rm, ri);
        #1;
        vectors++;
        if (dut_out !== exp_out) begin
            miscompares++;
            $display("FAIL model_cycle%0d {open,field,h,m,s,blink} got %b want %b", rst_q.size() - 1, dut_out, exp_out);
        end
    endtask

    typedef struct {
        bit         mode;
        bit         inc;
        int         cyc;
        bit         open;
        logic [2:0] field;
        int         h;
        int         m;
        int         s;
        int         blink;  // -1: not checked
    } row_t;

    row_t rows[$];

    function automatic void add_row(input bit md, input bit ic, input int c, input bit op,
                                    input logic [2:0] f, input int h, input int mi, input int s, input int bl);
        row_t r;
        r.mode = md; r.inc = ic; r.cyc = c; r.open = op; r.field = f;
        r.h = h; r.m = mi; r.s = s; r.blink = bl;
        rows.push_back(r);
    endfunction

    initial begin
        int ch, cm, cs, c;
        bit ok, rst_r;
        int ml, il;

        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        #1;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) tick(1'b1);
        vectors++;
        if (dut_out !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_state got %b want %b", dut_out, 8'b1000_0000);
        end

        add_row(0, 0, 4, 1, 3'b000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add_row(1, 0, 2, 1, 3'b000, 0, 0, 0, 0);
            add_row(0, 0, 2, 1, 3'b000, 0, 0, 0, 0);
        end
        add_row(1, 0, 12, 0, 3'b100, 0, 0, 0, 0);
        add_row(0, 0, 8,  0, 3'b100, 0, 0, 0, -1);
        add_row(1, 0, 8,  0, 3'b010, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b010, 0, 0, 0, -1);
        add_row(0, 1, 10, 0, 3'b010, 0, 2, 0, -1);
        add_row(0, 0, 10, 0, 3'b010, 0, 0, 0, -1);
        add_row(1, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(0, 1, 60, 0, 3'b001, 0, 0, 11, -1);
        add_row(0, 0, 30, 0, 3'b001, 0, 0, 1, -1);
        add_row(1, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(0, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(1, 0, 8,  0, 3'b100, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b100, 0, 0, 0, -1);
        add_row(1, 1, 10, 0, 3'b010, 0, 0, 0, -1);
        add_row(0, 1, 30, 0, 3'b010, 0, 0, 0, -1);
        add_row(0, 0, 10, 0, 3'b010, 0, 0, 0, -1);
        add_row(0, 1, 10, 0, 3'b010, 0, 2, 0, -1);
        add_row(0, 0, 10, 0, 3'b010, 0, 0, 0, -1);
        add_row(1, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(1, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(0, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(1, 0, 8,  0, 3'b100, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b100, 0, 0, 0, -1);
        add_row(1, 0, 8,  0, 3'b010, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b010, 0, 0, 0, -1);
        add_row(1, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(0, 0, 8,  0, 3'b001, 0, 0, 0, -1);
        add_row(1, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(0, 0, 8,  1, 3'b000, 0, 0, 0, 0);
        add_row(0, 1, 30, 1, 3'b000, 0, 0, 0, 0);
        add_row(0, 0, 10, 1, 3'b000, 0, 0, 0, 0);

        foreach (rows[r]) begin
            bus.btn_mode = rows[r].mode;
            bus.btn_inc  = rows[r].inc;
            ch = 0; cm = 0; cs = 0;
            for (int k = 0; k < rows[r].cyc; k++) begin
                tick(1'b0);
                ch += int'(bus.hour_add);
                cm += int'(bus.min_add);
                cs += int'(bus.sec_add);
            end
            ok = (bus.open === rows[r].open) && (bus.field_sel === rows[r].field) &&
                 (ch == rows[r].h) && (cm == rows[r].m) && (cs == rows[r].s) &&
                 (rows[r].blink < 0 || bus.blink === rows[r].blink[0]);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL row%0d got open=%b field=%b h=%0d m=%0d s=%0d blink=%b want open=%b field=%b h=%0d m=%0d s=%0d blink=%0d",
                         r, bus.open, bus.field_sel, ch, cm, cs, bus.blink,
                         rows[r].open, rows[r].field, rows[r].h, rows[r].m, rows[r].s, rows[r].blink);
            end
        end

        // blink phase from state entry
        bus.btn_mode = 1'b1;
        c = 0;
        while (bus.field_sel == 3'b000 && c < 20) begin tick(1'b0); c++; end
        vectors++;
        if (bus.field_sel != 3'b100) begin
            miscompares++;
            $display("FAIL blink_entry field got %b want %b", bus.field_sel, 3'b100);
        end
        c = 0;
        while (!bus.blink && c < 40) begin tick(1'b0); c++; end
        vectors++;
        if (c != B) begin miscompares++; $display("FAIL blink_rise cycles got %0d want %0d", c, B); end
        c = 0;
        while (bus.blink && c < 40) begin tick(1'b0); c++; end
        vectors++;
        if (c != B) begin miscompares++; $display("FAIL blink_fall cycles got %0d want %0d", c, B); end
        bus.btn_mode = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b0);

        // reset truncates an hour_add pulse
        bus.btn_inc = 1'b1;
        c = 0;
        while (!bus.hour_add && c < 20) begin tick(1'b0); c++; end
        vectors++;
        if (!bus.hour_add) begin miscompares++; $display("FAIL hour_pulse_start got 0 want 1"); end
        tick(1'b1);
        vectors++;
        if (dut_out !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_mid_pulse got %b want %b", dut_out, 8'b1000_0000);
        end
        tick(1'b1);
        bus.btn_inc = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0);

        // randomized button traffic against the model
        ml = 0; il = 0;
        for (int t = 0; t < 3000; t++) begin
            if (ml == 0) begin
                bus.btn_mode = ~bus.btn_mode;
                ml = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 45));
            end
            if (il == 0) begin
                bus.btn_inc = ~bus.btn_inc;
                if ($urandom_range(0, 9) < 3) il = int'($urandom_range(1, 5));
                else if (bus.btn_inc && $urandom_range(0, 3) == 0) il = int'($urandom_range(40, 80));
                else il = int'($urandom_range(6, 40));
            end
            ml--; il--;
            rst_r = ($urandom_range(0, 599) == 0);
            tick(rst_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
